// File: rtl/dram_slave_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface dram_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  be_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        err_o;
  logic        stallreq_o;
  logic        halt_o;

  modport master (
    output req_i, we_i, addr_i, data_i, be_i,
    input  data_o, ready_o, err_o, stallreq_o, halt_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i, be_i,
    output data_o, ready_o, err_o, stallreq_o, halt_o
  );
endinterface

// File: rtl/dram_slave.sv
// Latency-accurate data-memory responder: one outstanding word access, answered after LATENCY cycles.
// Optional halt MMIO register enabled by macro DRAM_HALT_MMIO_EN.
module dram_slave #(
  parameter int          RAM_SIZE       = 4096,
  parameter int          RAM_ADDR_WIDTH = 12,
  parameter int          LATENCY        = 2,
  parameter logic [31:0] HALT_ADDR      = 32'h0000_FFFC
) (
  input  logic   clk_i,
  input  logic   rst_i,
  dram_if.slave  bus
);

`ifdef DRAM_HALT_MMIO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        halt_q, halt_d;
  logic        mem_we;
  logic [31:0] mem [RAM_SIZE];

  logic [RAM_ADDR_WIDTH-1:0] idx;
  logic accept, halt_hit, oor, err;

  assign idx      = addr_q[RAM_ADDR_WIDTH+1:2];
  assign accept   = (state_q == IDLE) && bus.req_i;
  assign halt_hit = HALT_EN && (addr_q == HALT_ADDR);
  assign oor      = addr_q >= 32'(4 * RAM_SIZE);
  // The halt register lives outside the array range but is not an error.
  assign err      = (addr_q[1:0] != 2'b00) || (oor && !halt_hit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      if (accept) begin
        we_q    <= bus.we_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.data_i;
        be_q    <= bus.be_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    case (state_q)
      IDLE: if (bus.req_i) begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!bus.req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (we_q && halt_hit) halt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = 1'b0;
    bus.err_o   = 1'b0;
    bus.data_o  = '0;
    mem_we      = 1'b0;
    if (state_q == RESP) begin
      bus.ready_o = 1'b1;
      bus.err_o   = err;
      if (!we_q && !err)
        bus.data_o = halt_hit ? {31'b0, halt_q} : mem[idx];
      mem_we = we_q && !err && !halt_hit;
    end
  end

  // Array is intentionally not reset; the write lands on the RESP closing edge.
  always_ff @(posedge clk_i) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
  end

  assign bus.stallreq_o = bus.req_i && !bus.ready_o;
  assign bus.halt_o     = halt_q;

endmodule
